mux_select_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for a shared mux datapath (2x1 / 4x1 / wider mux trees built from gate-level mux cells).
- N requesters compete for one shared mux output.
- Produces a registered one-hot grant and a binary select word that drives the mux `sel` inputs directly.
- Select lines only change on clock edges and hold while idle, so the mux output never glitches from arbitration.

---
 rtl/mux_select_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_select_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving a shared mux: registered one-hot grant plus binary select.
// Define MUX_ARB_TIMEOUT_EN to add a hold counter that forces release after MAX_HOLD cycles.
module mux_select_arbiter #(
  parameter int N        = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);
  typedef enum logic {IDLE, OWNED} state_e;

  state_e           state_q;
  logic [N-1:0]     grant_q;
  logic [SEL_W-1:0] sel_q, ptr_q;
  logic             busy_q;

  logic [SEL_W-1:0] rel_ptr, win_idle, win_rel;
  logic             hit_idle, hit_rel, owner_req, expire;

  // First set bit of r scanning cyclically from start; returns {found, index}.
  function automatic logic [SEL_W:0] scan(input logic [N-1:0] r, input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (!found && r[SEL_W'(j)]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  // While owned, sel_q is the owner, so grant_q masks the owner out of the handoff scan.
  always_comb begin
    rel_ptr               = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + 1'b1;
    {hit_idle, win_idle}  = scan(req, ptr_q);
    {hit_rel, win_rel}    = scan(req & ~grant_q, rel_ptr);
    owner_req             = req[sel_q];
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign expire  = owner_req && (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign timeout = timeout_q;
`else
  logic [31:0] unused_max_hold;
  assign unused_max_hold = MAX_HOLD;
  assign expire          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef MUX_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (hit_idle) begin
            state_q <= OWNED;
            grant_q <= onehot(win_idle);
            sel_q   <= win_idle;
            busy_q  <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        OWNED: begin
          if (!owner_req || (expire && hit_rel)) begin
            ptr_q <= rel_ptr;
            if (hit_rel) begin
              grant_q <= onehot(win_rel);
              sel_q   <= win_rel;
`ifdef MUX_ARB_TIMEOUT_EN
              cnt_q     <= '0;
              timeout_q <= owner_req;
`endif
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end
          end
`ifdef MUX_ARB_TIMEOUT_EN
          else if (expire) cnt_q <= '0;
          else             cnt_q <= cnt_q + 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Bench for mux_select_arbiter: vector table, directed corner sequences, and random traffic
// checked against a queue-free behavioural model of the round-robin rules.
module tb_mux_select_arbiter;
  localparam int N        = 4;
  localparam int SEL_W    = 2;
  localparam int MAX_HOLD = 4;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req   = '0;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             busy;
`ifdef MUX_ARB_TIMEOUT_EN
  logic             timeout;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: owner (-1 when idle), rotation pointer, last owner, hold count.
  int m_owner, m_ptr, m_last, m_cnt;
  bit m_to;

  mux_select_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .sel   (sel),
`ifdef MUX_ARB_TIMEOUT_EN
    .timeout (timeout),
`endif
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] others;
    int pick;
    bit forced;
    m_to   = 0;
    forced = 0;
    if (m_owner < 0) begin
      pick = first_from(r, m_ptr);
      if (pick >= 0) begin m_owner = pick; m_last = pick; m_cnt = 0; end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      if (r[m_owner]) begin
        m_cnt++;
        if (m_cnt == MAX_HOLD) begin
          if (others != 0) forced = 1;
          else m_cnt = 0;
        end
      end
`endif
      if (!r[m_owner] || forced) begin
        m_ptr = (m_owner + 1) % N;
        pick  = first_from(others, m_ptr);
        m_to  = forced;
        if (pick >= 0) begin m_owner = pick; m_last = pick; m_cnt = 0; end
        else m_owner = -1;
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] r);
    req = r;
    model_edge(r);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, " grant"}, grant, eg);
    chk({tag, " sel"}, sel, m_last);
    chk({tag, " busy"}, busy, (m_owner >= 0));
`ifdef MUX_ARB_TIMEOUT_EN
    chk({tag, " timeout"}, timeout, m_to);
`endif
  endtask

  // Async reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
  } vec_t;

  vec_t tbl[13];
  logic [N-1:0] r, oh;

  initial begin
    tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[7]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
    tbl[8]  = '{4'b0011, 4'b0001, 2'd0, 1'b1};
    tbl[9]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
    tbl[11] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

    // Reset takes effect without any clock edge.
    req = 4'b1111;
    model_reset();
    #2;
    chk("reset grant", grant, 4'b0000);
    chk("reset sel", sel, 2'd0);
    chk("reset busy", busy, 1'b0);
    req = 4'b0000;
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].req);
      chk($sformatf("vec%0d grant", i), grant, tbl[i].grant);
      chk($sformatf("vec%0d sel", i), sel, tbl[i].sel);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
    end

    // Rotation with wrap: each owner holds 3 cycles, drops for one, re-raises.
    reset_pulse();
    tick(4'b1111);
    for (int k = 0; k < 5; k++) begin
      oh = '0;
      oh[k % 4] = 1'b1;
      chk($sformatf("rot%0d grant", k), grant, oh);
      chk($sformatf("rot%0d sel", k), sel, k % 4);
      if (k < 4) begin
        tick(4'b1111);
        tick(4'b1111);
        tick(4'b1111 & ~oh);
        chk($sformatf("rot%0d nobubble", k), busy, 1'b1);
      end
    end

    // Async reset while requester 3 owns; next scan restarts at index 0.
    tick(4'b1000);
    chk("mid grant pre", grant, 4'b1000);
    reset_pulse();
    chk("mid grant", grant, 4'b0000);
    chk("mid busy", busy, 1'b0);
    chk("mid sel", sel, 2'd0);
    tick(4'b1001);
    chk("post reset grant", grant, 4'b0001);
    tick(4'b0000);

`ifdef MUX_ARB_TIMEOUT_EN
    reset_pulse();
    for (int t = 0; t < 12; t++) begin
      tick(4'b0011);
      oh = '0;
      oh[(t / 4) % 2] = 1'b1;
      chk($sformatf("to%0d grant", t), grant, oh);
      chk($sformatf("to%0d pulse", t), timeout, (t > 0 && t % 4 == 0));
    end
    for (int t = 0; t < 10; t++) begin
      tick(4'b0001);
      chk($sformatf("solo%0d grant", t), grant, 4'b0001);
      chk($sformatf("solo%0d pulse", t), timeout, 1'b0);
    end
`endif

    // Random traffic with sticky requests against the model.
    reset_pulse();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      tick(r);
      cmp_model($sformatf("rnd%0d", c));
      if (busy) chk($sformatf("rnd%0d grant[sel]", c), grant[sel], 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
